control_sequencer: RTL and testbench

- Hardwired control unit for the MINI_SRC datapath.
- Decodes the 32-bit instruction register and sequences fetch/decode/execute by producing the datapath's one-hot control strobes each cycle.
- Performs the Gra/Grb/Grc select-and-encode into 16-bit reg_in/reg_out.
- Stalls on a memory-done handshake; implements halt.

---
 rtl/mini_src_ctrl_pkg.sv | 66 ++++++
 rtl/select_encode.sv | 35 +++
 rtl/control_sequencer.sv | 149 ++++++++++++++
 tb/tb_control_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_ctrl_pkg.sv
// rtl/mini_src_ctrl_pkg.sv - opcodes, sequencer states and instruction classes for the MINI_SRC control unit
package mini_src_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam logic [4:0] ALU_ADD = 5'b00011;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY,
    C_BR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } class_e;

  // Groups opcodes that share one micro-sequence; unknown opcodes run as nop.
  function automatic class_e decode_class(input logic [4:0] op);
    if (op >= OP_ADD && op <= OP_SHL) return C_ALU_R;
    case (op)
      OP_LD:                    return C_LD;
      OP_LDI:                   return C_LDI;
      OP_ST:                    return C_ST;
      OP_ADDI, OP_ANDI, OP_ORI: return C_ALU_I;
      OP_DIV, OP_MUL:           return C_MULDIV;
      OP_NEG, OP_NOT:           return C_UNARY;
      OP_BR:                    return C_BR;
      OP_IN:                    return C_IN;
      OP_OUT:                   return C_OUT;
      OP_MFHI:                  return C_MFHI;
      OP_MFLO:                  return C_MFLO;
      OP_HALT:                  return C_HALT;
      default:                  return C_NOP;
    endcase
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/select_encode.sv
// rtl/select_encode.sv - Gra/Grb/Grc field select and one-hot register enable encode
module select_encode
  import mini_src_ctrl_pkg::*;
(
  input  logic [31:0]         ir,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                ba_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out
);

  logic [3:0]          sel;
  logic [NUM_REGS-1:0] dec;
  logic                unused_ir_bits;

  // Opcode and constant bits play no part in register selection.
  assign unused_ir_bits = ^{ir[31:27], ir[14:0]};

  // Pick the requested field, decode one-hot; BAout still reads the selected register.
  always_comb begin
    sel = '0;
    if (gra)      sel = ir[26:23];
    else if (grb) sel = ir[22:19];
    else if (grc) sel = ir[18:15];
    dec = '0;
    if (gra || grb || grc) dec = NUM_REGS'(1) << sel;
    reg_in  = rin ? dec : '0;
    reg_out = (rout || ba_out) ? dec : '0;
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer for the MINI_SRC datapath
module control_sequencer
  import mini_src_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_done,
  input  logic                con_ff,
  output logic                PCout_en,
  output logic                PCin,
  output logic                IncPC,
  output logic                IRin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                Write,
  output logic                Yin,
  output logic                Zin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                HIout,
  output logic                LOin,
  output logic                LOout,
  output logic                Cout,
  output logic                BAout,
  output logic                inPortOut,
  output logic                outPort_en,
  output logic                CONin,
  output logic [4:0]          opcode,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                run
);

  state_e state_q, state_d;
  class_e cls;
  logic   gra, grb, grc, rin, rout;

  assign cls = decode_class(ir[31:27]);

  // State register; clear abandons any instruction in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_T0;
    else        state_q <= state_d;
  end

  // Next state: memory steps wait on mem_done, each class ends at its own last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_T0: state_d = S_T1;
      S_T1: if (mem_done) state_d = S_T2;
      S_T2: begin
        if (cls == C_HALT)     state_d = S_HALT;
        else if (cls == C_NOP) state_d = S_T0;
        else                   state_d = S_T3;
      end
      S_T3: state_d = (cls inside {C_IN, C_OUT, C_MFHI, C_MFLO}) ? S_T0 : S_T4;
      S_T4: state_d = (cls == C_UNARY) ? S_T0 : S_T5;
      S_T5: state_d = (cls inside {C_LD, C_ST, C_MULDIV, C_BR}) ? S_T6 : S_T0;
      S_T6: begin
        if (cls == C_LD)      state_d = mem_done ? S_T7 : S_T6;
        else if (cls == C_ST) state_d = S_T7;
        else                  state_d = S_T0;
      end
      S_T7: begin
        if (cls == C_ST) state_d = mem_done ? S_T0 : S_T7;
        else             state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  // Strobes per step; everything is forced low while clear is asserted.
  always_comb begin
    {PCout_en, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write} = '0;
    {Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout} = '0;
    {Cout, BAout, inPortOut, outPort_en, CONin} = '0;
    {gra, grb, grc, rin, rout} = '0;
    opcode = '0;
    run    = 1'b0;
    if (clear) begin
      run = (state_q != S_HALT);
      case (state_q)
        S_T0: begin PCout_en = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T3: case (cls)
          C_ALU_R, C_ALU_I:  begin grb = 1'b1; rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST: begin grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_MULDIV:          begin gra = 1'b1; rout = 1'b1; Yin = 1'b1; end
          C_UNARY:           begin grb = 1'b1; rout = 1'b1; opcode = ir[31:27]; Zin = 1'b1; end
          C_BR:              begin gra = 1'b1; rout = 1'b1; CONin = 1'b1; end
          C_IN:              begin inPortOut = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_OUT:             begin gra = 1'b1; rout = 1'b1; outPort_en = 1'b1; end
          C_MFHI:            begin HIout = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_MFLO:            begin LOout = 1'b1; gra = 1'b1; rin = 1'b1; end
          default: ;
        endcase
        S_T4: case (cls)
          C_ALU_R:           begin grc = 1'b1; rout = 1'b1; opcode = ir[31:27]; Zin = 1'b1; end
          C_ALU_I:           begin Cout = 1'b1; opcode = imm_alu_op(ir[31:27]); Zin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; opcode = ALU_ADD; Zin = 1'b1; end
          C_MULDIV:          begin grb = 1'b1; rout = 1'b1; opcode = ir[31:27]; Zin = 1'b1; end
          C_UNARY:           begin Zlowout = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_BR:              begin PCout_en = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
        S_T5: case (cls)
          C_ALU_R, C_ALU_I, C_LDI: begin Zlowout = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_LD, C_ST:              begin Zlowout = 1'b1; MARin = 1'b1; end
          C_MULDIV:                begin Zlowout = 1'b1; LOin = 1'b1; end
          C_BR:                    begin Cout = 1'b1; opcode = ALU_ADD; Zin = 1'b1; end
          default: ;
        endcase
        S_T6: case (cls)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin gra = 1'b1; rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          C_BR:     begin Zlowout = con_ff; PCin = con_ff; end
          default: ;
        endcase
        S_T7: case (cls)
          C_LD:    begin MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  select_encode u_select_encode (
    .ir      (ir),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin),
    .rout    (rout),
    .ba_out  (BAout),
    .reg_in  (reg_in),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_done = 1'b0;
  logic        con_ff = 1'b0;
  logic        PCout_en, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
  logic        Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
  logic        Cout, BAout, inPortOut, outPort_en, CONin, run;
  logic [4:0]  opcode;
  logic [15:0] reg_in, reg_out;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done), .con_ff(con_ff),
    .PCout_en(PCout_en), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write), .Yin(Yin), .Zin(Zin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .HIout(HIout), .LOin(LOin),
    .LOout(LOout), .Cout(Cout), .BAout(BAout), .inPortOut(inPortOut),
    .outPort_en(outPort_en), .CONin(CONin), .opcode(opcode), .reg_in(reg_in),
    .reg_out(reg_out), .run(run)
  );

  always #5 clock = ~clock;

  localparam logic [21:0] PCOUT = 22'd1 << 0,  PCIN  = 22'd1 << 1,  INCPC  = 22'd1 << 2;
  localparam logic [21:0] IRIN  = 22'd1 << 3,  MARIN = 22'd1 << 4,  MDRIN  = 22'd1 << 5;
  localparam logic [21:0] MDROUT = 22'd1 << 6, READ  = 22'd1 << 7,  WRITE  = 22'd1 << 8;
  localparam logic [21:0] YIN   = 22'd1 << 9,  ZIN   = 22'd1 << 10, ZHI    = 22'd1 << 11;
  localparam logic [21:0] ZLO   = 22'd1 << 12, HIIN  = 22'd1 << 13, HIOUT  = 22'd1 << 14;
  localparam logic [21:0] LOIN  = 22'd1 << 15, LOOUT = 22'd1 << 16, COUT   = 22'd1 << 17;
  localparam logic [21:0] BAO   = 22'd1 << 18, INPORT = 22'd1 << 19, OUTPORT = 22'd1 << 20;
  localparam logic [21:0] CONIN = 22'd1 << 21;

  typedef struct {
    logic [21:0] s;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
    bit          w;
  } step_t;

  step_t prog[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] observed();
    logic [21:0] s;
    s = {CONin, outPort_en, inPortOut, BAout, Cout, LOout, LOin, HIout, HIin, Zlowout,
         Zhighout, Zin, Yin, Write, Read, MDRout, MDRin, MARin, IRin, IncPC, PCin, PCout_en};
    return {4'b0, run, s, reg_in, reg_out, opcode};
  endfunction

  function automatic logic [63:0] expv(input step_t c);
    return {4'b0, 1'b1, c.s, c.rin, c.rout, c.opc};
  endfunction

  task automatic push(input logic [21:0] s, input logic [15:0] rin, input logic [15:0] rout,
                      input logic [4:0] opc, input bit w);
    step_t t;
    t.s = s; t.rin = rin; t.rout = rout; t.opc = opc; t.w = w;
    prog.push_back(t);
  endtask

  // Reference micro-sequence for one instruction, listed step by step from the instruction rules.
  task automatic build(input logic [31:0] instr, input bit cff);
    logic [4:0]  op;
    logic [15:0] ra, rb, rc;
    op = instr[31:27];
    ra = 16'd1 << instr[26:23];
    rb = 16'd1 << instr[22:19];
    rc = 16'd1 << instr[18:15];
    prog.delete();
    push(PCOUT | MARIN | INCPC | ZIN, 0, 0, 0, 0);
    push(ZLO | PCIN | READ | MDRIN, 0, 0, 0, 1);
    push(MDROUT | IRIN, 0, 0, 0, 0);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(YIN, 0, rb, 0, 0); push(ZIN, 0, rc, op, 0); push(ZLO, ra, 0, 0, 0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(YIN, 0, rb, 0, 0);
      push(COUT | ZIN, 0, 0, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6, 0);
      push(ZLO, ra, 0, 0, 0);
    end else if (op <= 5'd2) begin
      push(YIN | BAO, 0, rb, 0, 0); push(COUT | ZIN, 0, 0, 5'd3, 0);
      if (op == 5'd1) push(ZLO, ra, 0, 0, 0);
      else if (op == 5'd0) begin
        push(ZLO | MARIN, 0, 0, 0, 0); push(READ | MDRIN, 0, 0, 0, 1); push(MDROUT, ra, 0, 0, 0);
      end else begin
        push(ZLO | MARIN, 0, 0, 0, 0); push(MDRIN, 0, ra, 0, 0); push(WRITE, 0, 0, 0, 1);
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      push(YIN, 0, ra, 0, 0); push(ZIN, 0, rb, op, 0);
      push(ZLO | LOIN, 0, 0, 0, 0); push(ZHI | HIIN, 0, 0, 0, 0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(ZIN, 0, rb, op, 0); push(ZLO, ra, 0, 0, 0);
    end else if (op == 5'd19) begin
      push(CONIN, 0, ra, 0, 0); push(PCOUT | YIN, 0, 0, 0, 0);
      push(COUT | ZIN, 0, 0, 5'd3, 0); push(cff ? (ZLO | PCIN) : 22'd0, 0, 0, 0, 0);
    end else if (op == 5'd22) push(INPORT, ra, 0, 0, 0);
    else if (op == 5'd23) push(OUTPORT, 0, ra, 0, 0);
    else if (op == 5'd24) push(HIOUT, ra, 0, 0, 0);
    else if (op == 5'd25) push(LOOUT, ra, 0, 0, 0);
  endtask

  // Runs one instruction from T0, comparing every cycle against the reference steps.
  task automatic exec_instr(input logic [31:0] instr, input bit cff, input bit stall3,
                            input int abort_at);
    step_t cur;
    int popped = 0, cycles = 0, stalls = 0, rd = 0, irin = 0, hilo = 0;
    build(instr, cff);
    while (prog.size() > 0) begin
      @(negedge clock);
      if (cycles == 0) begin ir = instr; con_ff = cff; end
      #1;
      cycles++;
      cur = prog[0];
      check_eq("step", observed(), expv(cur));
      rd += int'(Read);
      irin += int'(IRin);
      hilo += int'(HIin | LOin);
      if (abort_at == popped) begin
        clear = 1'b0;
        #1;
        check_eq("clear_async", observed(), 64'h0);
        repeat (2) begin
          @(negedge clock); #1;
          hilo += int'(HIin | LOin);
          check_eq("clear_hold", observed(), 64'h0);
        end
        @(posedge clock); #2;
        clear = 1'b1;
        check_eq("no_hilo_pulse", 64'(hilo), 64'h0);
        prog.delete();
      end else begin
        if (stall3) begin
          mem_done = !(cur.w && stalls < 3);
          if (cur.w && !mem_done) stalls++;
        end else begin
          mem_done = ($urandom_range(0, 2) != 0);
        end
        if (!(cur.w && !mem_done)) begin
          void'(prog.pop_front());
          popped++;
        end
        if (cycles > 300) begin
          check_eq("timeout", 64'(cycles), 64'h0);
          prog.delete();
        end
      end
    end
    if (stall3) begin
      check_eq("t1_read_cycles", 64'(rd), 64'd4);
      check_eq("irin_once", 64'(irin), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] instr;
    logic [4:0]  op;

    #3;
    check_eq("reset", observed(), 64'h0);
    @(posedge clock); #2;
    clear = 1'b1;

    exec_instr(32'h18918000, 1'b0, 1'b1, -1);
    exec_instr(32'h09000065, 1'b0, 1'b0, -1);
    exec_instr(32'h98000000, 1'b0, 1'b0, -1);
    exec_instr(32'h98000000, 1'b1, 1'b0, -1);
    exec_instr({5'b10000, 4'd5, 4'd6, 19'd0}, 1'b0, 1'b0, 4);

    for (int i = 0; i < 120; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      instr = {op, 27'($urandom)};
      exec_instr(instr, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    exec_instr(32'hD8000000, 1'b0, 1'b0, -1);
    repeat (20) begin
      @(negedge clock); #1;
      check_eq("halt", observed(), 64'h0);
      mem_done = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    clear = 1'b0;
    #1;
    check_eq("halt_clear", observed(), 64'h0);
    @(posedge clock); #2;
    clear = 1'b1;
    exec_instr(32'h18918000, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
